bcd_updown_counter_7seg: RTL and testbench

//  Parametrised multi-digit BCD up/down counter with per-digit seven-segment outputs.

---
 rtl/counter_pkg.sv | 48 ++++
 rtl/bcd_to_7seg.sv | 22 ++
 rtl/bcd_updown_counter_7seg.sv | 171 +++++++++++++++++
 tb/tb_bcd_updown_counter_7seg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types, segment table and BCD helpers for the BCD counter
//
// Purpose : digit/segment types, active-low {g,f,e,d,c,b,a} decode table,
//           BCD <-> integer helpers used for limit compares and elaboration.
// Ports   : none (package).
package counter_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_LUT [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Up to six BCD digits, digit 0 in [3:0]; unused upper digits must be zero.
    function automatic int bcd_to_int(input logic [23:0] v);
        int acc;
        acc = 0;
        for (int i = 5; i >= 0; i--) begin
            acc = acc * 10 + int'(v[i*4 +: 4]);
        end
        return acc;
    endfunction

    function automatic logic [23:0] int_to_bcd(input int v);
        logic [23:0] r;
        int          rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - single BCD digit to active-low seven-segment decoder
//
// Purpose : combinational decode of one BCD digit; codes 10-15 or blank=1 show SEG_BLANK.
// Ports   : digit  in  4  BCD digit
//           blank  in  1  force all segments off
//           seg    out 7  active-low {g,f,e,d,c,b,a}
module bcd_to_7seg
    import counter_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_LUT[digit];
        end
    end

endmodule

// File: rtl/bcd_updown_counter_7seg.sv
// rtl/bcd_updown_counter_7seg.sv - multi-digit BCD up/down counter with 7-seg outputs
//
// Purpose : DIGITS-digit BCD counter wrapping at MAX_COUNT, with direction, enable,
//           validated parallel load, registered wrap / load_err pulses and per-digit
//           active-low segment outputs decoded straight from the count register.
// Config  : `define LEADING_ZERO_BLANK_EN blanks zero digits above the highest
//           non-zero digit (digit 0 always shown); otherwise all digits decode.
// Ports   : clk       in   1         rising-edge clock
//           rst       in   1         asynchronous active-low reset
//           en        in   1         count enable
//           up        in   1         1 = up, 0 = down
//           load      in   1         parallel load strobe (beats en)
//           load_val  in   DIGITS*4  BCD load value, units in [3:0]
//           bcd       out  DIGITS*4  current count, units in [3:0]
//           segs      out  DIGITS*7  active-low segments, digit 0 in [6:0]
//           wrap      out  1         pulse the cycle after a wrap edge
//           load_err  out  1         pulse the cycle after a rejected load
module bcd_updown_counter_7seg
    import counter_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MAX_COUNT = 99
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [DIGITS*4-1:0] load_val,
    output logic [DIGITS*4-1:0] bcd,
    output logic [DIGITS*7-1:0] segs,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = DIGITS * 4;

    if ((DIGITS < 1) || (DIGITS > 6) || (MAX_COUNT < 0) || (MAX_COUNT > 10**DIGITS - 1)) begin : g_bad_cfg
        $error("bcd_updown_counter_7seg: DIGITS must be 1..6 and MAX_COUNT <= 10**DIGITS-1");
    end

    localparam logic [23:0]  MAX_BCD_FULL = int_to_bcd(MAX_COUNT);
    localparam logic [W-1:0] MAX_BCD      = MAX_BCD_FULL[W-1:0];

    logic [W-1:0] bcd_q, bcd_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;

    logic [23:0]  cnt_pad, load_pad;
    int           cnt_val;
    logic         load_ok;
    logic [W-1:0] inc_val, dec_val;
    logic         inc_carry, dec_borrow;
    logic [DIGITS-1:0] blank;

    // Widen to the helper's fixed six-digit form so one compare function serves every DIGITS.
    always_comb begin
        cnt_pad           = '0;
        cnt_pad[W-1:0]    = bcd_q;
        load_pad          = '0;
        load_pad[W-1:0]   = load_val;
        cnt_val           = bcd_to_int(cnt_pad);
        load_ok           = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[i*4 +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
        if (bcd_to_int(load_pad) > MAX_COUNT) begin
            load_ok = 1'b0;
        end
    end

    // Decimal carry / borrow ripple: a digit only moves while every lower digit rolled over.
    always_comb begin
        inc_val    = bcd_q;
        dec_val    = bcd_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (bcd_q[i*4 +: 4] == 4'd9) begin
                    inc_val[i*4 +: 4] = 4'd0;
                end else begin
                    inc_val[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (bcd_q[i*4 +: 4] == 4'd0) begin
                    dec_val[i*4 +: 4] = 4'd9;
                end else begin
                    dec_val[i*4 +: 4] = bcd_q[i*4 +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bcd_d      = bcd_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                bcd_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (cnt_val >= MAX_COUNT) begin
                    bcd_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    bcd_d = inc_val;
                end
            end else begin
                if (cnt_val == 0) begin
                    bcd_d  = MAX_BCD;
                    wrap_d = 1'b1;
                end else begin
                    bcd_d = dec_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;
    always_comb begin
        blank   = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            blank[i] = !seen_nz;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_to_7seg u_seg (
            .digit (bcd_q[g*4 +: 4]),
            .blank (blank[g]),
            .seg   (segs[g*7 +: 7])
        );
    end

    assign bcd      = bcd_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// tb/tb_bcd_updown_counter_7seg.sv - scoreboard bench for the BCD up/down counter
module tb_bcd_updown_counter_7seg;

    localparam int DIGITS = 2;
    localparam int MAXC   = 59;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic [7:0]  bcd;
    logic [13:0] segs;
    logic        wrap, load_err;

    bcd_updown_counter_7seg #(.DIGITS(DIGITS), .MAX_COUNT(MAXC)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .segs     (segs),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bcd;
        logic        wrap;
        logic        lerr;
        logic [13:0] segs;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt   = 0;

    logic [6:0] tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic exp_t make_exp(input int c, input logic w, input logic le);
        exp_t e;
        int   tens, units;
        logic [6:0] s1;
        tens  = c / 10;
        units = c % 10;
        s1    = tab[tens];
`ifdef LEADING_ZERO_BLANK_EN
        if (tens == 0) s1 = 7'b1111111;
`endif
        e.bcd  = {4'(tens), 4'(units)};
        e.wrap = w;
        e.lerr = le;
        e.segs = {s1, tab[units]};
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (bcd !== e.bcd || wrap !== e.wrap || load_err !== e.lerr || segs !== e.segs) begin
            n_err++;
            $display("FAIL %s: got bcd=%h wrap=%b load_err=%b segs=%b, expected bcd=%h wrap=%b load_err=%b segs=%b",
                     name, bcd, wrap, load_err, segs, e.bcd, e.wrap, e.lerr, e.segs);
        end
    endtask

    // Drive one edge's inputs and push the model's view of the result.
    task automatic step(input logic e, input logic u, input logic l, input logic [7:0] lv);
        logic w, le;
        int   v;
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv;
        w  = 1'b0;
        le = 1'b0;
        v  = int'(lv[7:4]) * 10 + int'(lv[3:0]);
        if (l) begin
            if (lv[7:4] <= 4'd9 && lv[3:0] <= 4'd9 && v <= MAXC) cnt = v;
            else le = 1'b1;
        end else if (e) begin
            if (u) begin
                if (cnt == MAXC) begin cnt = 0; w = 1'b1; end
                else cnt = cnt + 1;
            end else begin
                if (cnt == 0) begin cnt = MAXC; w = 1'b1; end
                else cnt = cnt - 1;
            end
        end
        q.push_back(make_exp(cnt, w, le));
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; load = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("scoreboard", e);
            end
        end
    end

    initial begin : driver
        logic [7:0] lv;
        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1 check("reset_state", make_exp(0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Count up 12 edges through the 09->10 carry.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 8'h00);

        // Load 58, count up through 59 and the wrap to 00.
        step(1'b0, 1'b1, 1'b1, 8'h58);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Down from 0 wraps to 59, then 58, then direction flip back to 59.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);

        // Rejected loads (bad digit, over limit), with en high; then load beats en.
        step(1'b1, 1'b1, 1'b1, 8'h6A);
        step(1'b1, 1'b1, 1'b1, 8'h61);
        step(1'b1, 1'b1, 1'b1, 8'h60);
        step(1'b1, 1'b1, 1'b1, 8'h25);
        step(1'b1, 1'b0, 1'b1, 8'h07);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 1) lv = {4'($urandom_range(6, 0)), 4'($urandom_range(9, 0))};
            else lv = 8'($urandom);
            step(($urandom_range(3, 0) != 0), 1'($urandom), ($urandom_range(7, 0) == 0), lv);
        end

        // Asynchronous reset mid-count, while en is high.
        step(1'b0, 1'b1, 1'b1, 8'h37);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        load = 1'b0;
        #2 rst = 1'b0;
        #1 check("async_reset", make_exp(0, 1'b0, 1'b0));
        @(posedge clk);
        #1 check("reset_holds", make_exp(0, 1'b0, 1'b0));
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        cnt = 0;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        idle();

        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
